// File: rtl/u765_pkg.sv
// Shared types and constants for the u765 SD-image sector bridge.
// Imported by the bridge top level and its sector buffer.
package u765_pkg;

   localparam int SECTOR_BYTES = 512;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_REQ   = 3'd2,
      ST_XFER  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   typedef enum logic [2:0] {
      ERR_OK      = 3'd0,
      ERR_NOMOUNT = 3'd1,
      ERR_RANGE   = 3'd2,
      ERR_WPROT   = 3'd3,
      ERR_TIMEOUT = 3'd4
   } err_e;

endpackage

// File: rtl/u765_sd_bridge_if.sv
// SD host side of the u765 bridge: block request handshake plus sector buffer port.
// The bridge uses the master modport, the MiST(er) SD host uses the slave modport.
interface u765_sd_bridge_if #(
   parameter int DRIVES = 2
);
   logic [31:0]       sd_lba;
   logic [DRIVES-1:0] sd_rd;
   logic [DRIVES-1:0] sd_wr;
   logic              sd_ack;
   logic [8:0]        sd_buff_addr;
   logic [7:0]        sd_buff_dout;
   logic [7:0]        sd_buff_din;
   logic              sd_buff_wr;

   modport master (
      output sd_lba, sd_rd, sd_wr, sd_buff_din,
      input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
   );

   modport slave (
      input  sd_lba, sd_rd, sd_wr, sd_buff_din,
      output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
   );
endinterface

// File: rtl/u765_dpram.sv
// One-sector (512x8) dual-port buffer with registered read data on both ports.
// Port A faces the controller, port B faces the SD host; both run on the same clock.
module u765_dpram
   import u765_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       a_we,
   input  logic [8:0] a_addr,
   input  logic [7:0] a_din,
   output logic [7:0] a_dout,
   input  logic       b_we,
   input  logic [8:0] b_addr,
   input  logic [7:0] b_din,
   output logic [7:0] b_dout
);
   logic [7:0] mem [SECTOR_BYTES];
   logic [7:0] a_dout_q, a_dout_d;
   logic [7:0] b_dout_q, b_dout_d;

   always_ff @(posedge clk) begin
      if (a_we) mem[a_addr] <= a_din;
      if (b_we) mem[b_addr] <= b_din;
   end

   always_comb begin
      a_dout_d = mem[a_addr];
      b_dout_d = mem[b_addr];
   end

   // Only the read registers are reset; the array keeps its contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_dout_q <= '0;
         b_dout_q <= '0;
      end else begin
         a_dout_q <= a_dout_d;
         b_dout_q <= b_dout_d;
      end
   end

   assign a_dout = a_dout_q;
   assign b_dout = b_dout_q;

endmodule

// File: rtl/u765_sd_bridge.sv
// Multi-drive SD-image sector bridge: mount tracking, request range checks,
// sd_rd/sd_wr/sd_ack handshake with optional timeout and a shared sector buffer.
module u765_sd_bridge
   import u765_pkg::*;
#(
   parameter int  DRIVES  = 2,
   parameter int  TIMEOUT = 1048575,
   localparam int DW      = (DRIVES > 1) ? $clog2(DRIVES) : 1
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic [DRIVES-1:0] img_mounted,
   input  logic              img_wp,
   input  logic [31:0]       img_size,
   output logic [DRIVES-1:0] mounted,
   output logic [DRIVES-1:0] wp,
   input  logic              req,
   input  logic              req_wr,
   input  logic [DW-1:0]     req_drive,
   input  logic [31:0]       req_lba,
   output logic              busy,
   output logic              done,
   output logic [2:0]        err,
   input  logic [8:0]        buf_addr,
   input  logic [7:0]        buf_din,
   input  logic              buf_we,
   output logic [7:0]        buf_dout,
   u765_sd_bridge_if.master  sd
);
   localparam int            CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_e            state_q, state_d;
   err_e              err_q, err_d;
   logic [DW-1:0]     drv_q, drv_d;
   logic [31:0]       lba_q, lba_d;
   logic              wr_q, wr_d;
   logic [31:0]       sd_lba_q, sd_lba_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DRIVES-1:0] mounted_q, mounted_d;
   logic [DRIVES-1:0] wp_q, wp_d;
   logic [31:0]       size_q [DRIVES];
   logic [31:0]       size_d [DRIVES];

   logic              sel_mounted, sel_wp;
   logic [31:0]       sel_sectors;
   logic [DRIVES-1:0] drv_hot;
   logic              ram_b_we;
   logic [7:0]        sd_buff_din_w;

   always_comb begin
      mounted_d = mounted_q;
      wp_d      = wp_q;
      size_d    = size_q;
      for (int i = 0; i < DRIVES; i++) begin
         if (img_mounted[i]) begin
            mounted_d[i] = (img_size != 32'd0);
            wp_d[i]      = img_wp;
            size_d[i]    = img_size;
         end
      end
   end

   // A drive index beyond DRIVES selects nothing and so reads as unmounted.
   always_comb begin
      sel_mounted = 1'b0;
      sel_wp      = 1'b0;
      sel_sectors = '0;
      drv_hot     = '0;
      for (int i = 0; i < DRIVES; i++) begin
         if (drv_q == DW'(i)) begin
            sel_mounted = mounted_q[i];
            sel_wp      = wp_q[i];
            sel_sectors = {9'd0, size_q[i][31:9]};
            drv_hot[i]  = 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      err_d    = err_q;
      drv_d    = drv_q;
      lba_d    = lba_q;
      wr_d     = wr_q;
      sd_lba_d = sd_lba_q;
      cnt_d    = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               drv_d   = req_drive;
               lba_d   = req_lba;
               wr_d    = req_wr;
               err_d   = ERR_OK;
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            state_d = ST_DONE;
            if (!sel_mounted)           err_d = ERR_NOMOUNT;
            else if (lba_q >= sel_sectors) err_d = ERR_RANGE;
            else if (wr_q && sel_wp)    err_d = ERR_WPROT;
            else begin
               sd_lba_d = lba_q;
               cnt_d    = '0;
               state_d  = ST_REQ;
            end
         end
         ST_REQ: begin
            if (sd.sd_ack) begin
               state_d = ST_XFER;
            end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
               err_d   = ERR_TIMEOUT;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_XFER: begin
            if (!sd.sd_ack) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         err_q     <= ERR_OK;
         drv_q     <= '0;
         lba_q     <= '0;
         wr_q      <= 1'b0;
         sd_lba_q  <= '0;
         cnt_q     <= '0;
         mounted_q <= '0;
         wp_q      <= '0;
         for (int i = 0; i < DRIVES; i++) size_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         err_q     <= err_d;
         drv_q     <= drv_d;
         lba_q     <= lba_d;
         wr_q      <= wr_d;
         sd_lba_q  <= sd_lba_d;
         cnt_q     <= cnt_d;
         mounted_q <= mounted_d;
         wp_q      <= wp_d;
         size_q    <= size_d;
      end
   end

   assign busy    = (state_q == ST_CHECK) || (state_q == ST_REQ) || (state_q == ST_XFER);
   assign done    = (state_q == ST_DONE);
   assign err     = err_q;
   assign mounted = mounted_q;
   assign wp      = wp_q;

   assign sd.sd_lba      = sd_lba_q;
   assign sd.sd_rd       = ((state_q == ST_REQ) && !wr_q) ? drv_hot : '0;
   assign sd.sd_wr       = ((state_q == ST_REQ) &&  wr_q) ? drv_hot : '0;
   assign sd.sd_buff_din = sd_buff_din_w;

   // The SD host may only fill the buffer while a read transfer is acknowledged.
   assign ram_b_we = sd.sd_buff_wr && (state_q == ST_XFER) && !wr_q;

   u765_dpram u_ram (
      .clk    (clk_sys),
      .rst_n  (reset_n),
      .a_we   (buf_we && !busy),
      .a_addr (buf_addr),
      .a_din  (buf_din),
      .a_dout (buf_dout),
      .b_we   (ram_b_we),
      .b_addr (sd.sd_buff_addr),
      .b_din  (sd.sd_buff_dout),
      .b_dout (sd_buff_din_w)
   );

endmodule

// File: doc/u765_sd_bridge.md
# u765_sd_bridge

Parametrised SD-image sector bridge for the u765 floppy subsystem, generalising the fixed two-drive SD handshake to `DRIVES` channels. It tracks per-drive mount state, write-protect and image size, and range-checks sector requests before touching the SD host. It runs the `sd_rd`/`sd_wr`/`sd_ack` handshake with an optional timeout and buffers one 512-byte sector in a dual-port RAM shared by the controller and SD sides. It sits between the FDC core and the MiST(er) SD host interface.

## Interface
- `DRIVES`, 2: number of image channels, 1..4; `DW = max(1,$clog2(DRIVES))`.
- `TIMEOUT`, 1048575: `clk_sys` cycles to wait for `sd_ack` rise; 0 disables the timeout.

Ports:
- `clk_sys` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `img_mounted` in DRIVES: per-drive mount strobe.
- `img_wp` in 1: write protect, latched on a mount strobe.
- `img_size` in 32: image bytes, latched on a mount strobe.
- `mounted` out DRIVES: drive has a non-empty image.
- `wp` out DRIVES: latched write protect.
- `req` in 1: start request, sampled only when `busy=0`.
- `req_wr` in 1: 1 = write sector, 0 = read sector.
- `req_drive` in DW: target drive.
- `req_lba` in 32: sector index (512-byte units).
- `busy` out 1: request in progress.
- `done` out 1: one-cycle completion pulse.
- `err` out 3: status, valid from `done` until the next accepted `req`.
- `buf_addr` in 9: controller byte address.
- `buf_din` in 8: controller write data.
- `buf_we` in 1: controller write strobe, ignored while `busy=1`.
- `buf_dout` out 8: controller read data, 1-cycle latency.
- `sd_lba` out 32: SD block address.
- `sd_rd` out DRIVES: one-hot read request.
- `sd_wr` out DRIVES: one-hot write request.
- `sd_ack` in 1: SD host acknowledge.
- `sd_buff_addr` in 9: SD-side byte address.
- `sd_buff_dout` in 8: SD-side read data.
- `sd_buff_din` out 8: SD-side write data, 1-cycle latency.
- `sd_buff_wr` in 1: SD-side write strobe.

## Operation
Mount handling:
- On a cycle where `img_mounted[i]=1`, drive `i` latches `mounted[i] = (img_size != 0)`, `wp[i] = img_wp` and `size[i] = img_size`.
- Several bits may be set at once; each set drive latches the same values.
- A mount for the drive currently in use leaves the transfer in flight untouched; the new values apply from the next `req`.

Error codes:
- 0 OK.
- 1 NOMOUNT.
- 2 RANGE.
- 3 WPROT.
- 4 TIMEOUT.

FSM states and transitions:
- IDLE: on `req`, latch drive, lba and wr; set `busy=1`; go to CHECK.
- CHECK: evaluate in priority order:
  - `!mounted[drv]` gives NOMOUNT.
  - `lba >= size[drv]>>9` gives RANGE. A partial last sector is therefore out of range, and `lba=0xFFFFFFFF` is always RANGE.
  - `wr && wp[drv]` gives WPROT.
  - Any error goes to DONE. Otherwise load `sd_lba = lba` and go to REQ.
- REQ:
  - Hold `sd_rd[drv]` (read) or `sd_wr[drv]` (write) high; the timeout counter runs.
  - When `sd_ack=1`, clear the request and go to XFER.
  - If the counter reaches `TIMEOUT`, clear the request, set TIMEOUT and go to DONE.
- XFER: when `sd_ack=0`, go to DONE. No timeout applies here.
- DONE: pulse `done=1`, set `busy=0`, go to IDLE.

Buffer rules:
- `sd_buff_wr` writes the RAM only when in XFER and the request is a read; it is ignored otherwise.
- `sd_buff_din` always returns the RAM byte at `sd_buff_addr` of the previous cycle.
- A controller write (`buf_we`) to the same address in the same cycle as an SD write cannot happen, because `buf_we` is ignored while busy.

Reset:
- `reset_n=0` at any point, including mid-transfer, returns the FSM to IDLE immediately.
- All outputs go to 0: `busy`, `done`, `err`, `mounted`, `wp`, `sd_rd`, `sd_wr`, `sd_lba`. `buf_dout` and `sd_buff_din` read 0 until the first read after reset; RAM contents are not cleared.

## Timing
- `req` sampled at cycle N gives `busy=1` at N+1 (CHECK).
- Error path: `done` and `err` at N+2, with no SD strobe ever asserted.
- Good path:
  - `sd_rd` or `sd_wr` goes high at N+2.
  - The request drops the cycle after `sd_ack` is first sampled high.
  - `done` rises 1 cycle after `sd_ack` is sampled low in XFER.
- Timeout: the request is held exactly `TIMEOUT` cycles in REQ, then `done` follows 1 cycle later.
- A `req` held high in the cycle `done` pulses is not accepted; the next request is taken from IDLE in the following cycle.
- Mount strobe in cycle M: `mounted` and `wp` are updated at M+1.

## Structure
- Package `u765_pkg` holds:
  - the bridge state enum (IDLE, CHECK, REQ, XFER, DONE);
  - the 3-bit error enum;
  - the `SECTOR_BYTES=512` constant.
- Sub-module `u765_dpram`: a 512x8 true dual-port RAM with registered outputs.
  - Port A is the controller side.
  - Port B is the SD side.

## Test plan
- Reset with `DRIVES=2` -> all outputs 0. Then `req` to drive 0 -> `done` at N+2 with `err=1`, no `sd_rd`.
- Mount drive 1 with `img_size=0x2D000` (360 sectors), `img_wp=0`:
  - read `lba=359` -> `sd_rd=2'b10` at N+2 and `sd_lba=359`;
  - SD host writes 512 bytes during ack; `buf_dout` at address 0x1FF equals the last byte; `err=0`.
- Same image, `lba=360` -> `err=2`. Remount with `img_wp=1`, then write `lba=0` -> `err=3` with `sd_wr` never high.
- Write request: controller fills the buffer with 0x00..0xFF pattern -> `sd_wr` asserted; `sd_buff_din` follows `sd_buff_addr` with 1-cycle latency.
- Build with `TIMEOUT=16` and never assert `sd_ack` -> request high exactly 16 cycles, then `done` with `err=4`. Deassert `reset_n` mid-REQ -> `sd_rd=0` and `busy=0` asynchronously.
